// File: rtl/counter_dispatch_scheduler_pkg.sv
// Shared types, constants and helpers for the counter dispatch scheduler.
package counter_dispatch_scheduler_pkg;

    localparam int NUM_CNT   = 5;
    localparam int TICKET_W  = 6;
    localparam int CALL_HOLD = 4;
    localparam int PTR_W     = $clog2(NUM_CNT);
    localparam int HOLD_W    = $clog2(CALL_HOLD + 1);
    localparam int CALL_W    = 3;

    // Ticket value 0 and counter code 0 both mean "none".
    localparam logic [TICKET_W-1:0] TICKET_NONE    = TICKET_W'(0);
    localparam logic [TICKET_W-1:0] TICKET_ONE     = TICKET_W'(1);
    localparam logic [TICKET_W-1:0] TICKET_MAX     = {TICKET_W{1'b1}};
    localparam logic [TICKET_W-1:0] QUEUE_FULL_LVL = TICKET_MAX - TICKET_ONE;
    localparam logic [CALL_W-1:0]   COUNTER_NONE   = CALL_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_ANNOUNCE = 2'd2
    } state_e;

    // Next ticket number; skips the reserved 0 by wrapping max back to 1.
    function automatic logic [TICKET_W-1:0] ticket_inc(input logic [TICKET_W-1:0] t);
        logic [TICKET_W-1:0] r;
        if (t == TICKET_MAX) r = TICKET_ONE;
        else                 r = t + TICKET_ONE;
        return r;
    endfunction

    // Index of the set bit in a one-hot counter vector (0 when empty).
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_CNT-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = PTR_W'(0);
        for (int i = 0; i < NUM_CNT; i++) begin
            if (oh[i]) idx = PTR_W'(i);
            else       idx = idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/counter_dispatch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above the pointer,
// wrapping around, wins.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_valid_o
);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // Scan requests upward from the pointer and keep the first hit.
    always_comb begin
        gnt_o   = {N{1'b0}};
        found_s = 1'b0;
        sum_s   = {(PTR_W+1){1'b0}};
        idx_s   = {PTR_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            sum_s = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (sum_s >= (PTR_W+1)'(N)) sum_s = sum_s - (PTR_W+1)'(N);
            else                        sum_s = sum_s;
            idx_s = sum_s[PTR_W-1:0];
            if (!found_s && req_i[idx_s]) begin
                gnt_o[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        gnt_valid_o = found_s;
    end

endmodule

// File: rtl/counter_dispatch_scheduler.sv
// Ticket issuer, waiting queue count and round-robin call dispatcher.
module counter_dispatch_scheduler
    import counter_dispatch_scheduler_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                button_i,
    input  logic [NUM_CNT-1:0]  counter_free_i,
    input  logic [NUM_CNT-1:0]  counter_done_i,
    output logic [TICKET_W-1:0] current_number_o,
    output logic [TICKET_W-1:0] waiting_count_o,
    output logic                queue_full_o,
    output logic                call_valid_o,
    output logic [CALL_W-1:0]   counter_call_o,
    output logic [TICKET_W-1:0] number_service_o,
    output logic [NUM_CNT-1:0]  busy_o
);

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [TICKET_W-1:0]   cur_q, cur_d;
    logic [TICKET_W-1:0]   waiting_q, waiting_d;
    logic                  full_q, full_d;
    logic                  call_valid_q, call_valid_d;
    logic [CALL_W-1:0]     call_q, call_d;
    logic [TICKET_W-1:0]   serv_q, serv_d;
    logic [NUM_CNT-1:0]    busy_q, busy_d;

    logic [NUM_CNT-1:0]    elig_s;
    logic [NUM_CNT-1:0]    gnt_s;
    logic                  gnt_valid_s;
    logic [PTR_W-1:0]      gnt_idx_s;
    logic                  issue_s;
    logic                  grant_s;

    assign elig_s    = counter_free_i & ~busy_q;
    assign gnt_idx_s = onehot_to_idx(gnt_s);

    rr_arbiter #(
        .N     (NUM_CNT),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i       (elig_s),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt_s),
        .gnt_valid_o (gnt_valid_s)
    );

    // Next-state logic: FSM, ticket issue, queue count and busy tracking.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        call_valid_d = call_valid_q;
        call_d       = call_q;
        serv_d       = serv_q;
        grant_s      = 1'b0;
        busy_d       = busy_q & ~counter_done_i;
        issue_s      = button_i & ~full_q;

        case (state_q)
            ST_IDLE: begin
                if ((waiting_q != TICKET_NONE) && (elig_s != {NUM_CNT{1'b0}})) state_d = ST_GRANT;
                else                                                           state_d = ST_IDLE;
            end
            ST_GRANT: begin
                // A counter that dropped counter_free here aborts without side effects.
                if (gnt_valid_s) begin
                    grant_s      = 1'b1;
                    busy_d       = busy_d | gnt_s;
                    serv_d       = ticket_inc(serv_q);
                    call_d       = CALL_W'(gnt_idx_s) + CALL_W'(1);
                    hold_d       = HOLD_W'(CALL_HOLD);
                    call_valid_d = 1'b1;
                    state_d      = ST_ANNOUNCE;
                    if (gnt_idx_s == PTR_W'(NUM_CNT - 1)) ptr_d = PTR_W'(0);
                    else                                  ptr_d = gnt_idx_s + PTR_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ANNOUNCE: begin
                if (hold_q > HOLD_W'(1)) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    hold_d       = HOLD_W'(0);
                    call_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                hold_d       = HOLD_W'(0);
                call_valid_d = 1'b0;
            end
        endcase

        if (issue_s) cur_d = ticket_inc(cur_q);
        else         cur_d = cur_q;

        // A press and a grant on the same edge cancel out.
        case ({issue_s, grant_s})
            2'b10:   waiting_d = waiting_q + TICKET_ONE;
            2'b01:   waiting_d = waiting_q - TICKET_ONE;
            default: waiting_d = waiting_q;
        endcase

        full_d = (waiting_d == QUEUE_FULL_LVL);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ptr_q        <= PTR_W'(0);
            hold_q       <= HOLD_W'(0);
            cur_q        <= TICKET_NONE;
            waiting_q    <= TICKET_NONE;
            full_q       <= 1'b0;
            call_valid_q <= 1'b0;
            call_q       <= COUNTER_NONE;
            serv_q       <= TICKET_NONE;
            busy_q       <= {NUM_CNT{1'b0}};
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_q       <= hold_d;
            cur_q        <= cur_d;
            waiting_q    <= waiting_d;
            full_q       <= full_d;
            call_valid_q <= call_valid_d;
            call_q       <= call_d;
            serv_q       <= serv_d;
            busy_q       <= busy_d;
        end
    end

    assign current_number_o = cur_q;
    assign waiting_count_o  = waiting_q;
    assign queue_full_o     = full_q;
    assign call_valid_o     = call_valid_q;
    assign counter_call_o   = call_q;
    assign number_service_o = serv_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_counter_dispatch_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the ticket/call scheduler.
module tb_counter_dispatch_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic [4:0] free = 5'b0;
    logic [4:0] done = 5'b0;

    logic [5:0] current_number;
    logic [5:0] waiting_count;
    logic       queue_full;
    logic       call_valid;
    logic [2:0] counter_call;
    logic [5:0] number_service;
    logic [4:0] busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    int         m_cur = 0, m_wait = 0, m_serv = 0, m_call = 0, m_ptr = 0;
    int         m_left = 0;
    int         m_phase = 0;  // 0 waiting for work, 1 arbitration cycle, 2 announcing
    logic [4:0] m_busy = 5'b0;

    always #5 clk = ~clk;

    counter_dispatch_scheduler dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .button_i         (button),
        .counter_free_i   (free),
        .counter_done_i   (done),
        .current_number_o (current_number),
        .waiting_count_o  (waiting_count),
        .queue_full_o     (queue_full),
        .call_valid_o     (call_valid),
        .counter_call_o   (counter_call),
        .number_service_o (number_service),
        .busy_o           (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        logic [4:0] elig;
        int g, old_wait, c;
        bit grant, accept;
        if (rst) begin
            m_cur = 0; m_wait = 0; m_serv = 0; m_call = 0; m_ptr = 0;
            m_left = 0; m_phase = 0; m_busy = 5'b0;
            return;
        end
        elig  = free & ~m_busy;
        grant = 0;
        g     = 0;
        if (m_phase == 1) begin
            for (int k = 0; k < 5; k++) begin
                c = (m_ptr + k) % 5;
                if (!grant && elig[c]) begin grant = 1; g = c; end
            end
        end
        accept   = button && (m_wait != 62);
        old_wait = m_wait;
        m_busy   = m_busy & ~done;
        if (accept) begin
            m_wait++;
            m_cur = (m_cur == 63) ? 1 : m_cur + 1;
        end
        if (grant) begin
            m_wait--;
            m_busy[g] = 1'b1;
            m_serv = (m_serv == 63) ? 1 : m_serv + 1;
            m_call = g + 1;
            m_ptr  = (g + 1) % 5;
            m_left = 4;
            m_phase = 2;
        end else if (m_phase == 1) begin
            m_phase = 0;
        end else if (m_phase == 2) begin
            m_left--;
            if (m_left == 0) m_phase = 0;
        end else if (old_wait > 0 && elig != 5'b0) begin
            m_phase = 1;
        end
    endtask

    // One clock: update model at the edge, compare all outputs just after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("current_number", int'(current_number), m_cur);
        check("waiting_count",  int'(waiting_count),  m_wait);
        check("queue_full",     int'(queue_full),     (m_wait == 62) ? 1 : 0);
        check("call_valid",     int'(call_valid),     (m_left > 0) ? 1 : 0);
        check("counter_call",   int'(counter_call),   m_call);
        check("number_service", int'(number_service), m_serv);
        check("busy",           int'(busy),           int'(m_busy));
    endtask

    task automatic do_reset();
        rst = 1'b1; button = 1'b0; done = 5'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        int vcnt;
        int rise[3];
        int nr;
        bit prev_v;

        // --- single press, all counters free ---
        free = 5'b11111;
        do_reset();
        check("reset_cur", int'(current_number), 0);
        check("reset_busy", int'(busy), 0);
        button = 1'b1; tick(); button = 1'b0;
        check("t1_cur", int'(current_number), 1);
        check("t1_wait", int'(waiting_count), 1);
        tick();
        check("t1_valid_early", int'(call_valid), 0);
        tick();
        check("t1_call", int'(counter_call), 1);
        check("t1_serv", int'(number_service), 1);
        check("t1_busy", int'(busy), 5'b00001);
        check("t1_wait0", int'(waiting_count), 0);
        vcnt = int'(call_valid);
        for (int i = 0; i < 8; i++) begin tick(); vcnt += int'(call_valid); end
        check("t1_hold_len", vcnt, 4);

        // --- done on an idle counter leaves busy alone ---
        done = 5'b00010; tick(); done = 5'b0;
        check("idle_done_busy", int'(busy), 5'b00001);

        // --- three presses, grants spaced CALL_HOLD+2 ---
        do_reset();
        nr = 0; prev_v = 1'b0;
        for (int i = 0; i < 22; i++) begin
            button = (i < 3) ? 1'b1 : 1'b0;
            tick();
            if (call_valid && !prev_v && nr < 3) begin rise[nr] = cyc; nr++; end
            prev_v = call_valid;
        end
        button = 1'b0;
        check("t2_ngrants", nr, 3);
        check("t2_space01", rise[1] - rise[0], 6);
        check("t2_space12", rise[2] - rise[1], 6);
        check("t2_busy", int'(busy), 5'b00111);
        check("t2_call", int'(counter_call), 3);
        check("t2_serv", int'(number_service), 3);

        // --- all busy, two waiting, done on counter D ---
        do_reset();
        for (int i = 0; i < 40; i++) begin
            button = (i < 7) ? 1'b1 : 1'b0;
            tick();
        end
        check("t3_busy_all", int'(busy), 5'b11111);
        check("t3_wait2", int'(waiting_count), 2);
        done = 5'b01000; tick(); done = 5'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t3_call", int'(counter_call), 4);
        check("t3_serv", int'(number_service), 6);
        check("t3_wait1", int'(waiting_count), 1);
        check("t3_busy", int'(busy), 5'b11111);

        // --- fill the queue, then wrap the ticket number ---
        free = 5'b0;
        do_reset();
        button = 1'b1;
        for (int i = 0; i < 63; i++) tick();
        button = 1'b0;
        check("t4_cur62", int'(current_number), 62);
        check("t4_wait62", int'(waiting_count), 62);
        check("t4_full", int'(queue_full), 1);
        free = 5'b00001;
        for (int i = 0; i < 3; i++) tick();
        free = 5'b0;
        check("t4_wait61", int'(waiting_count), 61);
        button = 1'b1; tick(); button = 1'b0;
        check("t4_cur63", int'(current_number), 63);
        for (int i = 0; i < 6; i++) tick();
        done = 5'b00001; free = 5'b00001; tick(); done = 5'b0;
        for (int i = 0; i < 3; i++) tick();
        free = 5'b0;
        button = 1'b1; tick(); button = 1'b0;
        check("t4_wrap1", int'(current_number), 1);

        // --- press coincides with grant edge ---
        free = 5'b11111;
        do_reset();
        button = 1'b1; tick();
        button = 1'b0; tick();
        button = 1'b1; tick(); button = 1'b0;
        check("t5_grant", int'(counter_call), 1);
        check("t5_wait_same", int'(waiting_count), 1);

        // --- reset in the middle of an announcement ---
        tick();
        check("t6_in_announce", int'(call_valid), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_valid0", int'(call_valid), 0);
        check("t6_call0", int'(counter_call), 0);
        check("t6_busy0", int'(busy), 0);
        check("t6_cur0", int'(current_number), 0);
        check("t6_wait0", int'(waiting_count), 0);
        button = 1'b1; tick(); button = 1'b0;
        tick(); tick();
        check("t6_regrant_A", int'(counter_call), 1);

        // --- random traffic against the model ---
        for (int i = 0; i < 4000; i++) begin
            button = ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) free = 5'($urandom_range(0, 31));
            done = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'b0;
            rst  = ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0;
            tick();
        end
        rst = 1'b0; button = 1'b0; done = 5'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
